solar_track_ctrl: RTL and testbench
===================================

Name: solar_track_ctrl

Overview:
- Upstream stage of the servo PWM generator in the light-tracking datapath.
- Compares two light-sensor samples (sensor A vs sensor B) using a hysteresis deadband and a persistence filter.
- Runs a move/settle state machine with end-stop and timeout protection.
- Drives the 2-bit direction code and enable that the PWM stage consumes. Runs on the 1 MHz divided clock (1 cycle = 1 us).

Parameters:
- DATA_W, 12, sensor sample width (unsigned).
- DB_ON, 64, |A-B| must exceed this to start a move.
- DB_OFF, 16, a move ends when signed error toward the moving side drops to <= this; requires DB_OFF < DB_ON.
- CONFIRM_N, 4, consecutive same-side valid samples required before moving.
- SETTLE_CYC, 20000, stop-hold cycles after any move ends.
- MOVE_MAX, 2000000, max cycles in one move before FAULT.

Ports:
- CLK  in  1  1 MHz clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  master tracking enable (level).
- VALID  in  1  one-cycle strobe: LDR_A/LDR_B hold a new sample pair.
- LDR_A  in  DATA_W  sensor A sample (unsigned).
- LDR_B  in  DATA_W  sensor B sample (unsigned).
- LIM_A  in  1  end-stop on the A side (level, synchronised upstream).
- LIM_B  in  1  end-stop on the B side.
- DIR  out  2  00 = stop, 01 = toward A, 10 = toward B; 11 is never driven.
- EN  out  1  enable to the PWM stage.
- FAULT  out  1  move timeout latched.
- BUSY  out  1  high in MOVE_A, MOVE_B, SETTLE.

Behaviour:
- Clock and reset are decided: one clock, CLK; reset is RST, asynchronous, active-high.
- Reset values: DIR = 00, EN = 0, FAULT = 0, BUSY = 0, state = IDLE, all counters 0.
- All outputs are registered and update on the same edge as the state register.
- Error: err = signed(A) - signed(B), DATA_W+1 bits, no saturation needed.
- Candidate per VALID sample:
  - A if err > DB_ON.
  - B if err < -DB_ON.
  - otherwise NONE.
- EN = registered ENABLE, except 0 while in FAULT.
- ENABLE low, any state: next state IDLE, DIR = 00, confirm/settle/move counters cleared. FAULT is cleared only by this path or by reset.
- IDLE (DIR 00), on each VALID:
  - Candidate NONE: confirm count cleared.
  - Candidate equal to the previous candidate: increment confirm count; otherwise restart it at 1.
  - Count reaches CONFIRM_N with candidate A and LIM_A = 0: go to MOVE_A, DIR = 01.
  - Count reaches CONFIRM_N with candidate B and LIM_B = 0: go to MOVE_B, DIR = 10.
  - Candidate blocked by its limit: stay in IDLE, count held at CONFIRM_N-1.
  - Non-VALID cycles do not affect the count.
- MOVE_A (DIR 01), priority order:
  1. LIM_A = 1: go to SETTLE on the next edge, regardless of VALID.
  2. Move counter reaches MOVE_MAX-1: go to FAULT.
  3. VALID with err <= DB_OFF (includes reversal): go to SETTLE.
- MOVE_B (DIR 10): mirror of MOVE_A, using LIM_B and -err <= DB_OFF.
- Move counter: cleared on entry to a MOVE state, increments every cycle while in it.
- SETTLE (DIR 00):
  - Counts SETTLE_CYC cycles, then goes to IDLE with the confirm count cleared.
  - VALID samples are ignored.
- FAULT: DIR = 00, FAULT = 1, EN = 0. Held until ENABLE = 0.
- Simultaneous LIM and timeout on the same edge: the LIM path wins (SETTLE, no FAULT).
- Reset mid-move: DIR = 00 asynchronously.
- Latency: a VALID at edge k that completes confirmation gives DIR valid after edge k (same-edge registered).

Decomposition:
- Shared package (servo_pkg):
  - DIR encoding constants DIR_STOP/DIR_A/DIR_B.
  - State encoding IDLE/MOVE_A/MOVE_B/SETTLE/FAULT.
  - Candidate encoding NONE/A/B.
- One sub-module, ldr_compare: combinational err computation plus candidate and within-DB_OFF flags, pure function of LDR_A/LDR_B.
- The FSM and counters live in solar_track_ctrl.

Test Plan (sim params: DB_ON=64, DB_OFF=16, CONFIRM_N=4, SETTLE_CYC=10, MOVE_MAX=100):
1. Reset, ENABLE=1, four VALID pairs A=1000/B=900: DIR=01 after the 4th VALID edge, BUSY=1; three pairs then A=950/B=940 gives no move (count cleared).
2. In MOVE_A, send A=910/B=900 (err 10 <= 16): DIR=00 next edge; DIR stays 00 for 10 cycles despite VALID A=1000/B=800, then returns to IDLE; a move occurs only after 4 fresh confirms.
3. Hysteresis: in MOVE_B, err=-40 keeps DIR=10; err=-16 stops it.
4. LIM_A asserted mid-MOVE_A, no VALID: DIR=00 one edge later, state SETTLE. In IDLE with LIM_A=1 and a confirmed A candidate: DIR stays 00.
5. Timeout: hold err=+200 in MOVE_A for 100 cycles: FAULT=1, EN=0, DIR=00. ENABLE low for 1 cycle: FAULT=0, IDLE. Same-cycle LIM_A and timeout gives SETTLE with FAULT=0.
6. Async RST pulse mid-MOVE_B, between clock edges: DIR=00, EN=0, BUSY=0 immediately; DIR=11 never observed in any test (assertion).

Source files
------------

// File: rtl/servo_pkg.sv
// Shared encodings for the light-tracking servo path:
// direction code, controller state and sensor candidate.
package servo_pkg;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_A    = 2'b01;
   localparam logic [1:0] DIR_B    = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_A,
      ST_MOVE_B,
      ST_SETTLE,
      ST_FAULT
   } state_e;

   typedef enum logic [1:0] {
      CAND_NONE = 2'd0,
      CAND_A    = 2'd1,
      CAND_B    = 2'd2
   } cand_e;

endpackage

// File: rtl/ldr_compare.sv
// Signed A-B error with deadband classification.
// Purely combinational.
module ldr_compare
   import servo_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int DB_ON  = 64,
   parameter int DB_OFF = 16
) (
   input  logic [DATA_W-1:0] ldr_a_i,
   input  logic [DATA_W-1:0] ldr_b_i,
   output cand_e             cand_o,
   output logic              near_a_o,
   output logic              near_b_o
);

   localparam logic signed [DATA_W:0] ON_P  = (DATA_W+1)'(DB_ON);
   localparam logic signed [DATA_W:0] ON_N  = -ON_P;
   localparam logic signed [DATA_W:0] OFF_P = (DATA_W+1)'(DB_OFF);
   localparam logic signed [DATA_W:0] OFF_N = -OFF_P;

   logic signed [DATA_W:0] err;

   assign err = $signed({1'b0, ldr_a_i}) - $signed({1'b0, ldr_b_i});

   always_comb begin
      cand_o = CAND_NONE;
      if (err > ON_P) begin
         cand_o = CAND_A;
      end else if (err < ON_N) begin
         cand_o = CAND_B;
      end
   end

   // Reversal falls inside these too, so a swing past zero stops a move.
   assign near_a_o = (err <= OFF_P);
   assign near_b_o = (err >= OFF_N);

endmodule

// File: rtl/solar_track_ctrl.sv
// Light-tracking move/settle controller feeding the servo PWM stage.
// Persistence-filtered start, hysteretic stop, end-stop and timeout.
module solar_track_ctrl
   import servo_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int DB_ON      = 64,
   parameter int DB_OFF     = 16,
   parameter int CONFIRM_N  = 4,
   parameter int SETTLE_CYC = 20000,
   parameter int MOVE_MAX   = 2000000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENABLE,
   input  logic              VALID,
   input  logic [DATA_W-1:0] LDR_A,
   input  logic [DATA_W-1:0] LDR_B,
   input  logic              LIM_A,
   input  logic              LIM_B,
   output logic [1:0]        DIR,
   output logic              EN,
   output logic              FAULT,
   output logic              BUSY
);

   localparam int CW = $clog2(CONFIRM_N + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int MW = $clog2(MOVE_MAX + 1);

   state_e          state_q;
   cand_e           prev_q;
   logic [CW-1:0]   conf_q;
   logic [CW-1:0]   conf_d;
   logic [SW-1:0]   set_q;
   logic [MW-1:0]   mv_q;
   logic [1:0]      dir_q;
   logic            en_q;
   logic            fault_q;
   logic            busy_q;
   cand_e           cand;
   logic            near_a;
   logic            near_b;
   logic            hit;
   logic            mv_end;
   logic            set_end;

   ldr_compare #(
      .DATA_W (DATA_W),
      .DB_ON  (DB_ON),
      .DB_OFF (DB_OFF)
   ) u_cmp (
      .ldr_a_i  (LDR_A),
      .ldr_b_i  (LDR_B),
      .cand_o   (cand),
      .near_a_o (near_a),
      .near_b_o (near_b)
   );

   always_comb begin
      conf_d = CW'(1);
      if (cand == prev_q) begin
         conf_d = conf_q + CW'(1);
      end
   end

   assign hit     = (conf_d == CW'(CONFIRM_N));
   assign mv_end  = (mv_q == MW'(MOVE_MAX - 1));
   assign set_end = (set_q == SW'(SETTLE_CYC - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         prev_q  <= CAND_NONE;
         conf_q  <= '0;
         set_q   <= '0;
         mv_q    <= '0;
         dir_q   <= DIR_STOP;
         en_q    <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         en_q <= ENABLE;
         if (!ENABLE) begin
            state_q <= ST_IDLE;
            prev_q  <= CAND_NONE;
            conf_q  <= '0;
            set_q   <= '0;
            mv_q    <= '0;
            dir_q   <= DIR_STOP;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (VALID) begin
                     prev_q <= cand;
                     if (cand == CAND_NONE) begin
                        conf_q <= '0;
                     end else if (!hit) begin
                        conf_q <= conf_d;
                     end else if (cand == CAND_A && !LIM_A) begin
                        state_q <= ST_MOVE_A;
                        dir_q   <= DIR_A;
                        busy_q  <= 1'b1;
                        mv_q    <= '0;
                        conf_q  <= '0;
                        prev_q  <= CAND_NONE;
                     end else if (cand == CAND_B && !LIM_B) begin
                        state_q <= ST_MOVE_B;
                        dir_q   <= DIR_B;
                        busy_q  <= 1'b1;
                        mv_q    <= '0;
                        conf_q  <= '0;
                        prev_q  <= CAND_NONE;
                     end else begin
                        // Blocked by end-stop: retry on every further sample.
                        conf_q <= CW'(CONFIRM_N - 1);
                     end
                  end
               end
               ST_MOVE_A, ST_MOVE_B: begin
                  if ((state_q == ST_MOVE_A) ? LIM_A : LIM_B) begin
                     state_q <= ST_SETTLE;
                     dir_q   <= DIR_STOP;
                     set_q   <= '0;
                  end else if (mv_end) begin
                     state_q <= ST_FAULT;
                     dir_q   <= DIR_STOP;
                     busy_q  <= 1'b0;
                     fault_q <= 1'b1;
                     en_q    <= 1'b0;
                  end else if (VALID &&
                               ((state_q == ST_MOVE_A) ? near_a : near_b)) begin
                     state_q <= ST_SETTLE;
                     dir_q   <= DIR_STOP;
                     set_q   <= '0;
                  end else begin
                     mv_q <= mv_q + MW'(1);
                  end
               end
               ST_SETTLE: begin
                  if (set_end) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     set_q   <= '0;
                     conf_q  <= '0;
                     prev_q  <= CAND_NONE;
                  end else begin
                     set_q <= set_q + SW'(1);
                  end
               end
               ST_FAULT: begin
                  en_q <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  dir_q   <= DIR_STOP;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign DIR   = dir_q;
   assign EN    = en_q;
   assign FAULT = fault_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_solar_track_ctrl.sv
// Directed bench for solar_track_ctrl: confirm, hysteresis,
// settle, end-stops, timeout and async reset.
module tb_solar_track_ctrl;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        valid;
   logic [11:0] ldr_a;
   logic [11:0] ldr_b;
   logic        lim_a;
   logic        lim_b;
   logic [1:0]  dir;
   logic        en;
   logic        fault;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int bad_dir  = 0;

   solar_track_ctrl #(
      .DATA_W     (12),
      .DB_ON      (64),
      .DB_OFF     (16),
      .CONFIRM_N  (4),
      .SETTLE_CYC (10),
      .MOVE_MAX   (100)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .ENABLE (enable),
      .VALID  (valid),
      .LDR_A  (ldr_a),
      .LDR_B  (ldr_b),
      .LIM_A  (lim_a),
      .LIM_B  (lim_b),
      .DIR    (dir),
      .EN     (en),
      .FAULT  (fault),
      .BUSY   (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (dir === 2'b11) bad_dir++;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int a, input int b);
      ldr_a = 12'(a);
      ldr_b = 12'(b);
      valid = 1'b1;
      cyc();
      valid = 1'b0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic disable_cycle();
      enable = 1'b0;
      cyc();
      enable = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; valid = 1'b0;
      ldr_a = '0; ldr_b = '0; lim_a = 1'b0; lim_b = 1'b0;
      #22;
      checks++;
      if ({dir, en, fault, busy} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_out: got=%b want=00000", {dir, en, fault, busy});
      end
      #5 rst = 1'b0;
      enable = 1'b1;
      cyc();
      checks++;
      if (en !== 1'b1 || dir !== 2'b00) begin
         failures++;
         $display("FAIL enable_reg: en=%b dir=%b want en=1 dir=00", en, dir);
      end
   endtask

   task automatic test_confirm();
      for (int i = 0; i < 3; i++) begin
         send(1000, 900);
         cyc();
      end
      checks++;
      if (dir !== 2'b00) begin
         failures++;
         $display("FAIL confirm_3: dir=%b want=00", dir);
      end
      send(950, 940);
      for (int i = 0; i < 3; i++) send(1000, 900);
      checks++;
      if (dir !== 2'b00) begin
         failures++;
         $display("FAIL confirm_cleared: dir=%b want=00", dir);
      end
      send(1000, 900);
      checks++;
      if (dir !== 2'b01 || busy !== 1'b1) begin
         failures++;
         $display("FAIL confirm_move_a: dir=%b busy=%b want 01/1", dir, busy);
      end
   endtask

   task automatic test_stop_settle();
      send(910, 900);
      checks++;
      if (dir !== 2'b00 || busy !== 1'b1) begin
         failures++;
         $display("FAIL stop_db_off: dir=%b busy=%b want 00/1", dir, busy);
      end
      for (int i = 1; i <= 10; i++) begin
         send(1000, 800);
         checks++;
         if (dir !== 2'b00 || busy !== (i < 10)) begin
            failures++;
            $display("FAIL settle_%0d: dir=%b busy=%b want dir=00 busy=%0d",
                     i, dir, busy, i < 10);
         end
      end
      for (int i = 0; i < 3; i++) send(1000, 800);
      checks++;
      if (dir !== 2'b00) begin
         failures++;
         $display("FAIL settle_fresh3: dir=%b want=00", dir);
      end
      send(1000, 800);
      checks++;
      if (dir !== 2'b01) begin
         failures++;
         $display("FAIL settle_fresh4: dir=%b want=01", dir);
      end
      disable_cycle();
      checks++;
      if (dir !== 2'b00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL disable_stop: dir=%b busy=%b want 00/0", dir, busy);
      end
   endtask

   task automatic test_deadband_edge();
      for (int i = 0; i < 4; i++) send(1064, 1000);
      checks++;
      if (dir !== 2'b00) begin
         failures++;
         $display("FAIL db_on_64: dir=%b want=00", dir);
      end
      for (int i = 0; i < 4; i++) send(935, 1000);
      checks++;
      if (dir !== 2'b10) begin
         failures++;
         $display("FAIL db_on_m65: dir=%b want=10", dir);
      end
      disable_cycle();
   endtask

   task automatic test_hysteresis();
      for (int i = 0; i < 4; i++) send(900, 1000);
      checks++;
      if (dir !== 2'b10) begin
         failures++;
         $display("FAIL hyst_move_b: dir=%b want=10", dir);
      end
      send(960, 1000);
      send(983, 1000);
      checks++;
      if (dir !== 2'b10) begin
         failures++;
         $display("FAIL hyst_m40_m17: dir=%b want=10", dir);
      end
      send(984, 1000);
      checks++;
      if (dir !== 2'b00 || busy !== 1'b1) begin
         failures++;
         $display("FAIL hyst_m16: dir=%b busy=%b want 00/1", dir, busy);
      end
      idle_n(10);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL hyst_settle_done: busy=%b want=0", busy);
      end
   endtask

   task automatic test_limit();
      for (int i = 0; i < 4; i++) send(1000, 900);
      lim_a = 1'b1;
      cyc();
      checks++;
      if (dir !== 2'b00 || busy !== 1'b1) begin
         failures++;
         $display("FAIL lim_stop: dir=%b busy=%b want 00/1", dir, busy);
      end
      idle_n(10);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL lim_settle_done: busy=%b want=0", busy);
      end
      for (int i = 0; i < 5; i++) send(1000, 900);
      checks++;
      if (dir !== 2'b00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL lim_blocked: dir=%b busy=%b want 00/0", dir, busy);
      end
      lim_a = 1'b0;
      send(1000, 900);
      checks++;
      if (dir !== 2'b01) begin
         failures++;
         $display("FAIL lim_release: dir=%b want=01", dir);
      end
      disable_cycle();
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 4; i++) send(1000, 900);
      for (int i = 0; i < 99; i++) send(1200, 1000);
      checks++;
      if (dir !== 2'b01 || fault !== 1'b0) begin
         failures++;
         $display("FAIL tmo_99: dir=%b fault=%b want 01/0", dir, fault);
      end
      send(1200, 1000);
      checks++;
      if ({dir, en, fault, busy} !== 5'b00010) begin
         failures++;
         $display("FAIL tmo_fault: got=%b want=00010", {dir, en, fault, busy});
      end
      idle_n(3);
      checks++;
      if (fault !== 1'b1 || en !== 1'b0) begin
         failures++;
         $display("FAIL tmo_hold: fault=%b en=%b want 1/0", fault, en);
      end
      enable = 1'b0;
      cyc();
      checks++;
      if (fault !== 1'b0 || dir !== 2'b00) begin
         failures++;
         $display("FAIL tmo_clear: fault=%b dir=%b want 0/00", fault, dir);
      end
      enable = 1'b1;
      cyc();
      checks++;
      if (en !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tmo_reenable: en=%b busy=%b want 1/0", en, busy);
      end
      for (int i = 0; i < 4; i++) send(1000, 900);
      idle_n(99);
      lim_a = 1'b1;
      cyc();
      lim_a = 1'b0;
      checks++;
      if ({dir, fault, busy} !== 4'b0001) begin
         failures++;
         $display("FAIL tmo_lim_tie: dir/fault/busy=%b want=0001",
                  {dir, fault, busy});
      end
      idle_n(10);
      checks++;
      if (busy !== 1'b0 || fault !== 1'b0) begin
         failures++;
         $display("FAIL tie_settle: busy=%b fault=%b want 0/0", busy, fault);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) send(900, 1000);
      checks++;
      if (dir !== 2'b10) begin
         failures++;
         $display("FAIL ares_move_b: dir=%b want=10", dir);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({dir, en, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL ares_async: dir/en/busy=%b want=0000", {dir, en, busy});
      end
      #2 rst = 1'b0;
      cyc();
      checks++;
      if (en !== 1'b1 || dir !== 2'b00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ares_after: en=%b dir=%b busy=%b want 1/00/0",
                  en, dir, busy);
      end
   endtask

   initial begin
      test_reset();
      test_confirm();
      test_stop_settle();
      test_deadband_edge();
      test_hysteresis();
      test_limit();
      test_timeout();
      test_async_reset();
      checks++;
      if (bad_dir != 0) begin
         failures++;
         $display("FAIL dir_11_seen: count=%0d want=0", bad_dir);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
